// File: rtl/anc_pkg.sv
// rtl/anc_pkg.sv - shared ANC types, constants, FSM states and saturating add
package anc_pkg;

  localparam int DATA_W   = 11;
  localparam int TAPS     = 16;
  localparam int MU_SHIFT = 6;
  localparam int IDX_W    = 4;
  localparam int PROD_W   = 2 * DATA_W;
  localparam int D_SHIFT  = DATA_W - 1 + MU_SHIFT;

  typedef logic signed [DATA_W-1:0] sample_t;
  typedef logic signed [PROD_W-1:0] prod_t;

  localparam sample_t SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam sample_t SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_UPDATE,
    ST_DONE
  } state_t;

  // One guard bit is enough: a sign flip between the top two bits means overflow.
  function automatic sample_t sat_add(input sample_t a, input sample_t b);
    logic [DATA_W:0] s;
    s = {a[DATA_W-1], a} + {b[DATA_W-1], b};
    if (s[DATA_W] != s[DATA_W-1]) begin
      return s[DATA_W] ? SAT_MIN : SAT_MAX;
    end
    return s[DATA_W-1:0];
  endfunction

endpackage

// File: rtl/anc_tap_delay.sv
// rtl/anc_tap_delay.sv - reference-sample tap delay line with indexed read port
module anc_tap_delay
  import anc_pkg::*;
#(
  parameter int DEPTH = TAPS,
  parameter int WIDTH = DATA_W,
  parameter int IW    = IDX_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             shift_en,
  input  logic             clr,
  input  logic [WIDTH-1:0] din,
  input  logic [IW-1:0]    rd_idx,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] x [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) x[i] <= '0;
    end else if (clr) begin
      for (int i = 0; i < DEPTH; i++) x[i] <= '0;
    end else if (shift_en) begin
      x[0] <= din;
      for (int i = 1; i < DEPTH; i++) x[i] <= x[i-1];
    end
  end

  assign rd_data = x[rd_idx];

endmodule

// File: rtl/anc_lms_update.sv
// rtl/anc_lms_update.sv - sign-correct power-of-two-step LMS weight update, one tap per clock
module anc_lms_update
  import anc_pkg::*;
(
  input  logic              Clk_100M,
  input  logic              Reset_n,
  input  logic              FilterEN,
  input  logic              Synch,
  input  logic              Clear,
  input  logic [DATA_W-1:0] SigIn,
  input  logic [DATA_W-1:0] ErrIn,
  output logic [DATA_W-1:0] Wz,
  output logic [IDX_W-1:0]  WzIdx,
  output logic              WzValid,
  output logic              Busy,
  output logic              Overrun
);

  state_t             state;
  logic [IDX_W-1:0]   k;
  logic               synch_q;
  sample_t            e_r;
  sample_t            w [TAPS];

  logic               synch_rise;
  logic               clr_now;
  logic               edge_det;
  logic [IDX_W-1:0]   calc_idx;
  logic [DATA_W-1:0]  x_rd;
  sample_t            x_op;
  sample_t            e_op;
  prod_t              prod;
  sample_t            d;
  sample_t            w_new;

  assign synch_rise = Synch & ~synch_q & FilterEN;
  assign clr_now    = Clear & (state == ST_IDLE);
  assign edge_det   = synch_rise & (state == ST_IDLE) & ~Clear;

  // Tap 0 is computed in the edge cycle straight from the inputs so the
  // registered outputs carry tap k during cycle E+1+k; UPDATE works one tap ahead.
  assign calc_idx = (state == ST_IDLE) ? '0 : k + 1'b1;
  assign x_op     = edge_det ? $signed(SigIn) : $signed(x_rd);
  assign e_op     = edge_det ? $signed(ErrIn) : e_r;
  assign prod     = prod_t'(x_op) * prod_t'(e_op);
  assign d        = sample_t'(prod >>> D_SHIFT);
  assign w_new    = sat_add(w[calc_idx], d);

  anc_tap_delay u_tap_delay (
    .clk      (Clk_100M),
    .rst_n    (Reset_n),
    .shift_en (edge_det),
    .clr      (clr_now),
    .din      (SigIn),
    .rd_idx   (calc_idx),
    .rd_data  (x_rd)
  );

  always_ff @(posedge Clk_100M or negedge Reset_n) begin
    if (!Reset_n) begin
      state   <= ST_IDLE;
      k       <= '0;
      synch_q <= 1'b0;
      e_r     <= '0;
      Wz      <= '0;
      WzIdx   <= '0;
      WzValid <= 1'b0;
      Busy    <= 1'b0;
      Overrun <= 1'b0;
      for (int i = 0; i < TAPS; i++) w[i] <= '0;
    end else begin
      synch_q <= Synch;
      WzValid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (clr_now) begin
            Overrun <= 1'b0;
            for (int i = 0; i < TAPS; i++) w[i] <= '0;
          end else if (edge_det) begin
            e_r           <= $signed(ErrIn);
            k             <= '0;
            Busy          <= 1'b1;
            state         <= ST_UPDATE;
            w[calc_idx]   <= w_new;
            Wz            <= w_new;
            WzIdx         <= calc_idx;
            WzValid       <= 1'b1;
          end
        end
        ST_UPDATE: begin
          if (synch_rise) Overrun <= 1'b1;
          if (k == IDX_W'(TAPS - 1)) begin
            state <= ST_DONE;
          end else begin
            k             <= k + 1'b1;
            w[calc_idx]   <= w_new;
            Wz            <= w_new;
            WzIdx         <= calc_idx;
            WzValid       <= 1'b1;
          end
        end
        ST_DONE: begin
          if (synch_rise) Overrun <= 1'b1;
          Busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          Busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
